// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master engine.
//   - spi_state_t      : engine FSM states (IDLE, SETUP, SHIFT, HOLD)
//   - DEF_WIDTH        : default word width (matches the FIFO width)
//   - DEF_CLK_DIV      : default SCLK half-period in clk_i cycles
//   - edge_cnt_width() : width of the SCLK edge counter for a given word width
package spi_pkg;

  localparam int unsigned DEF_WIDTH   = 32;
  localparam int unsigned DEF_CLK_DIV = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_SHIFT = 2'd2,
    ST_HOLD  = 2'd3
  } spi_state_t;

  // One frame has 2*width SCLK edges, numbered 0..2*width-1.
  function automatic int unsigned edge_cnt_width(input int unsigned width);
    return $clog2(2 * width);
  endfunction

endpackage

// File: rtl/spi_clk_div.sv
// SCLK half-period divider.
//   clk_i  : system clock
//   rst_i  : asynchronous active-high reset
//   run_i  : counter runs while high, held at 0 while low
//   tick_o : high for one cycle when the counter reaches g_clk_div-1
module spi_clk_div
  import spi_pkg::*;
#(
  parameter int unsigned g_clk_div = DEF_CLK_DIV
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic run_i,
  output logic tick_o
);

  localparam int unsigned CW = (g_clk_div > 1) ? $clog2(g_clk_div) : 1;
  localparam logic [CW-1:0] LAST = CW'(g_clk_div - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else if (!run_i || (r_cnt == LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign tick_o = run_i & (r_cnt == LAST);

endmodule

// File: rtl/spi_master_engine.sv
// SPI shift engine between the TX and RX FIFOs.
// Pops words from a show-ahead TX FIFO, shifts them out MSB-first on MOSI
// while shifting in MISO, and pushes each received word into the RX FIFO.
// Supports all four CPOL/CPHA modes; CS stays asserted across back-to-back words.
//   clk_i, rst_i          : clock, asynchronous active-high reset
//   enable_i              : allows new frames to start
//   cpol_i, cpha_i        : SPI mode, latched at frame start
//   tx_data_i, tx_empty_i : TX FIFO head word and empty flag
//   tx_pull_o             : one-cycle TX pop strobe
//   rx_data_o, rx_push_o  : received word and one-cycle RX push strobe
//   rx_full_i             : RX FIFO full
//   busy_o                : high from capture until return to IDLE
//   sclk_o, mosi_o, miso_i, cs_n_o : SPI pins
module spi_master_engine
  import spi_pkg::*;
#(
  parameter int unsigned g_width   = DEF_WIDTH,
  parameter int unsigned g_clk_div = DEF_CLK_DIV
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               enable_i,
  input  logic               cpol_i,
  input  logic               cpha_i,
  input  logic [g_width-1:0] tx_data_i,
  input  logic               tx_empty_i,
  output logic               tx_pull_o,
  output logic [g_width-1:0] rx_data_o,
  input  logic               rx_full_i,
  output logic               rx_push_o,
  output logic               busy_o,
  output logic               sclk_o,
  output logic               mosi_o,
  input  logic               miso_i,
  output logic               cs_n_o
);

  localparam int unsigned EW = edge_cnt_width(g_width);
  localparam logic [EW-1:0] LAST_EDGE = EW'(2 * g_width - 1);

  spi_state_t         r_state;
  logic [g_width-1:0] r_tx_sr;
  logic [g_width-1:0] r_rx_sr;
  logic [EW-1:0]      r_edge;
  logic               r_cpol;
  logic               r_cpha;

  logic w_tick;
  logic w_run;
  logic w_start;
  logic w_capture;

  assign w_run   = (r_state != ST_IDLE);
  // RX space is reserved up front, so the push at frame end can never overflow.
  assign w_start = enable_i & ~tx_empty_i & ~rx_full_i;
  assign w_capture = w_start &
                     ((r_state == ST_IDLE) | ((r_state == ST_HOLD) & w_tick));

  spi_clk_div #(
    .g_clk_div(g_clk_div)
  ) u_clk_div (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .run_i (w_run),
    .tick_o(w_tick)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= ST_IDLE;
      r_tx_sr   <= '0;
      r_rx_sr   <= '0;
      r_edge    <= '0;
      r_cpol    <= 1'b0;
      r_cpha    <= 1'b0;
      cs_n_o    <= 1'b1;
      sclk_o    <= 1'b0;
      mosi_o    <= 1'b0;
      tx_pull_o <= 1'b0;
      rx_push_o <= 1'b0;
      busy_o    <= 1'b0;
      rx_data_o <= '0;
    end else begin
      tx_pull_o <= 1'b0;
      rx_push_o <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          cs_n_o <= 1'b1;
          sclk_o <= cpol_i;
        end

        ST_SETUP: begin
          if (w_tick) begin
            r_state <= ST_SHIFT;
            r_edge  <= '0;
          end
        end

        ST_SHIFT: begin
          if (w_tick) begin
            sclk_o <= (r_edge == LAST_EDGE) ? r_cpol : ~sclk_o;
            if (!r_edge[0]) begin
              // leading edge
              if (!r_cpha) begin
                r_rx_sr <= {r_rx_sr[g_width-2:0], miso_i};
              end else begin
                mosi_o  <= r_tx_sr[g_width-1];
                r_tx_sr <= r_tx_sr << 1;
              end
            end else begin
              // trailing edge
              if (r_cpha) begin
                r_rx_sr <= {r_rx_sr[g_width-2:0], miso_i};
              end else if (r_edge != LAST_EDGE) begin
                mosi_o  <= r_tx_sr[g_width-2];
                r_tx_sr <= r_tx_sr << 1;
              end
            end
            if (r_edge == LAST_EDGE) begin
              // With CPHA=1 the final sample lands on this very edge.
              rx_data_o <= r_cpha ? {r_rx_sr[g_width-2:0], miso_i} : r_rx_sr;
              rx_push_o <= 1'b1;
              r_state   <= ST_HOLD;
            end else begin
              r_edge <= r_edge + EW'(1);
            end
          end
        end

        ST_HOLD: begin
          if (w_tick && !w_start) begin
            cs_n_o  <= 1'b1;
            busy_o  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end

        default: r_state <= ST_IDLE;
      endcase

      // Shared by the IDLE start and the back-to-back start from HOLD.
      if (w_capture) begin
        r_tx_sr   <= tx_data_i;
        r_rx_sr   <= '0;
        mosi_o    <= tx_data_i[g_width-1];
        r_cpol    <= cpol_i;
        r_cpha    <= cpha_i;
        sclk_o    <= cpol_i;
        cs_n_o    <= 1'b0;
        busy_o    <= 1'b1;
        tx_pull_o <= 1'b1;
        r_state   <= ST_SETUP;
      end
    end
  end

endmodule

// File: doc/spi_master_engine.md
Name: spi_master_engine

Overview:
- SPI shift engine between the TX and RX FIFOs of the AXI_SPI_IF bridge.
- Pulls words from the TX FIFO, shifts them out MSB-first on MOSI, and shifts in the MISO word simultaneously.
- Pushes each received word into the RX FIFO.
- Drives SCLK/CS_n for all four CPOL/CPHA modes and keeps CS asserted across back-to-back words.

Parameters:
- g_width, 32: word width in bits; must equal the FIFO width.
- g_clk_div, 4: SCLK half-period in clk_i cycles, ≥1. SCLK = f_clk / (2*g_clk_div).

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  asynchronous, active-high reset
- enable_i  in  1  allows new frames to start
- cpol_i  in  1  SCLK idle level; latched at frame start
- cpha_i  in  1  0: sample on leading edge; 1: sample on trailing edge; latched at frame start
- tx_data_i  in  g_width  TX FIFO head word (show-ahead)
- tx_empty_i  in  1  TX FIFO empty
- tx_pull_o  out  1  one-cycle pop strobe to TX FIFO
- rx_data_o  out  g_width  received word
- rx_full_i  in  1  RX FIFO full
- rx_push_o  out  1  one-cycle push strobe to RX FIFO
- busy_o  out  1  high from capture until return to IDLE
- sclk_o  out  1  SPI clock
- mosi_o  out  1  SPI data out
- miso_i  in  1  SPI data in
- cs_n_o  out  1  chip select, active low

Behaviour:
- Reset (async, rst_i=1): state IDLE; counters 0; cs_n_o=1, sclk_o=0, mosi_o=0, tx_pull_o=0, rx_push_o=0, busy_o=0, rx_data_o=0.
  - Reset mid-frame aborts immediately. No push is issued and the partial word is lost.
- Divider: counter runs 0..g_clk_div-1 in SETUP/SHIFT/HOLD; "tick" when it equals g_clk_div-1, then it wraps to 0. The counter is held at 0 in IDLE.
- Start condition S = enable_i & !tx_empty_i & !rx_full_i.
  - RX free space is checked before the frame starts. The engine is the sole RX producer, so a push never meets a full RX FIFO.
- IDLE:
  - cs_n_o=1, sclk_o=cpol_i.
  - When S: capture cycle.
    - tx_pull_o=1 for that one cycle.
    - shift register ← tx_data_i; cpol/cpha latched; cs_n_o←0; busy_o←1.
    - Next state SETUP.
- SETUP: one tick of CS-to-first-edge setup, then SHIFT with edge count 0.
- SHIFT: each tick toggles sclk_o. Edge k runs 0..2*g_width-1; even k is a leading edge, odd k is a trailing edge.
  - CPHA=0:
    - mosi_o = bit g_width-1 from the capture cycle.
    - Leading edges sample miso_i into the RX shift register LSB.
    - Trailing edges present the next bit. The last trailing edge presents nothing new.
  - CPHA=1:
    - Leading edges present bit g_width-1-k/2.
    - Trailing edges sample miso_i.
  - After edge 2*g_width-1 (SCLK back at CPOL):
    - rx_data_o ← received word.
    - rx_push_o=1 for exactly the next cycle.
    - Next state HOLD.
- HOLD: one tick of CS hold, then:
  - If S: capture the next word (same actions as the IDLE capture), cs_n_o stays 0, go to SETUP.
  - Else: cs_n_o←1, busy_o←0, go to IDLE.
- Frame length: 1 + g_clk_div*(2*g_width+2) cycles from capture to the HOLD exit decision.
- enable_i deasserted mid-frame: the current word completes; no new start.
- cpol_i/cpha_i changes mid-frame are ignored until the next capture.
- tx_pull_o and rx_push_o are never asserted in the same cycle.
- miso_i is sampled directly; the I/O register lives outside this block.

Decomposition:
- Shared package spi_pkg:
  - state encoding constants: IDLE, SETUP, SHIFT, HOLD.
  - edge-count width clog2(2*g_width).
  - default g_width/g_clk_div.
- Sub-module spi_clk_div: parameter g_clk_div; inputs clk_i, rst_i, run_i; output tick_o.
- The FSM, shift registers and edge counter stay in spi_master_engine.

Test Plan:
- Mode 0, g_width=8, g_clk_div=2, TX holds 0xA5, MISO slave returns 0x3C:
  - one tx_pull_o; MOSI on leading edges reads 1,0,1,0,0,1,0,1.
  - rx_push_o once with rx_data_o=0x3C.
  - cs_n_o low for exactly 1+2*(16+2)-1 cycles before rising.
- Mode 3 (CPOL=1, CPHA=1), TX=0x81, MISO=0xFF:
  - sclk_o idles 1; MOSI changes only on falling edges; sampling on rising edges.
  - rx_data_o=0xFF.
- Back-to-back: three words 0x11, 0x22, 0x33 queued, enable_i=1:
  - cs_n_o stays low across all three words.
  - three pulls and three pushes in order.
  - busy_o drops only after the third HOLD.
- Boundaries:
  - rx_full_i=1 with TX non-empty: no start; sclk/cs idle.
  - Release rx_full_i: start on the next cycle.
  - tx_empty_i=1: no pull ever issued.
- Async rst_i asserted at SHIFT edge 7: outputs reset immediately with no clock edge; no rx_push_o; next frame after reset is correct.
- enable_i dropped during SHIFT of word 1 of 2: word 1 completes and is pushed; CS released; word 2 remains in TX.
